sram_bus_arbiter: RTL

SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

---
 rtl/sram_bus_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one single-cycle SRAM between an instruction port and a data port.
// Grant is combinational (addr_ok in the request cycle); data_ok follows one cycle later.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin conflict resolution. When it is
// undefined, data wins conflicts unless a 2-bit starvation counter has saturated for inst.
module sram_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  // instruction port
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // shared SRAM
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  logic        w_pick_inst;
  logic        w_gnt_inst;
  logic        w_gnt_data;
  logic        w_gnt_any;
  logic        w_wr;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_wen;

  logic        r_resp_valid;
  logic        r_resp_owner;  // 1: response belongs to the data port

`ifdef ARB_ROUND_ROBIN_EN
  logic        r_last_data;   // 1: most recent grant went to data
`else
  logic [1:0]  r_starve;      // consecutive cycles inst_req was denied, saturating
`endif

  // Conflict winner: least-recently granted port, or data unless inst is starved
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    w_pick_inst = r_last_data;
`else
    w_pick_inst = (r_starve == 2'd3);
`endif
  end

  // Grant decision; nothing is granted while reset is held
  always_comb begin
    w_gnt_inst = 1'b0;
    w_gnt_data = 1'b0;
    if (!rst) begin
      if (inst_req && data_req) begin
        w_gnt_inst = w_pick_inst;
        w_gnt_data = ~w_pick_inst;
      end else begin
        w_gnt_inst = inst_req;
        w_gnt_data = data_req;
      end
    end
    w_gnt_any = w_gnt_inst | w_gnt_data;
  end

  // Route the winner's request fields and derive byte-lane write enables
  always_comb begin
    w_wr    = w_gnt_data ? data_wr    : inst_wr;
    w_size  = w_gnt_data ? data_size  : inst_size;
    w_addr  = w_gnt_data ? data_addr  : inst_addr;
    w_wdata = w_gnt_data ? data_wdata : inst_wdata;
    w_wen   = 4'b0000;
    if (w_gnt_any && w_wr) begin
      case (w_size)
        2'd0:    w_wen = 4'b0001 << w_addr[1:0];
        2'd1:    w_wen = 4'b0011 << {w_addr[1], 1'b0};
        default: w_wen = 4'b1111;
      endcase
    end
  end

  // Output drive: SRAM strobes and handshake flags
  always_comb begin
    sram_en      = w_gnt_any;
    sram_wen     = w_wen;
    sram_addr    = {w_addr[31:2], 2'b00};
    sram_wdata   = w_wdata;
    inst_addr_ok = w_gnt_inst;
    data_addr_ok = w_gnt_data;
    inst_data_ok = r_resp_valid & ~r_resp_owner;
    data_data_ok = r_resp_valid & r_resp_owner;
    inst_rdata   = sram_rdata;
    data_rdata   = sram_rdata;
  end

  // Response tracking: every grant produces exactly one data_ok on the next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_owner <= 1'b0;
    end else begin
      r_resp_valid <= w_gnt_any;
      r_resp_owner <= w_gnt_data;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin pointer: remember which port won last; reset means inst went last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_data <= 1'b0;
    end else if (w_gnt_any) begin
      r_last_data <= w_gnt_data;
    end
  end
`else
  // Starvation counter: count denied inst cycles, clear when inst is served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= 2'd0;
    end else if (w_gnt_inst) begin
      r_starve <= 2'd0;
    end else if (inst_req && (r_starve != 2'd3)) begin
      r_starve <= r_starve + 2'd1;
    end
  end
`endif

endmodule
